// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART clocking constants and divisor type. The default
//               divisor is derived from the system clock, baud rate and
//               oversample ratio as a fixed-point clocks-per-os_tick value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int CLOCK_FREQ = 16000;
  localparam int BAUD_RATE  = 100;
  localparam int OVERSAMPLE = 16;
  localparam int DIV_W_DEF  = 16;
  localparam int FRAC_W_DEF = 4;

  // Clocks per oversample tick in fixed point with frac_w fractional bits.
  function automatic int calc_div_fixed(input int clk_hz, input int baud,
                                        input int os, input int frac_w);
    return (clk_hz << frac_w) / (baud * os);
  endfunction

  localparam int DIV_FIXED        = calc_div_fixed(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE, FRAC_W_DEF);
  localparam int DEFAULT_DIV_INT  = DIV_FIXED >> FRAC_W_DEF;
  localparam int DEFAULT_DIV_FRAC = DIV_FIXED % (1 << FRAC_W_DEF);

  typedef struct packed {
    logic [DIV_W_DEF-1:0]  div_int;
    logic [FRAC_W_DEF-1:0] div_frac;
  } divisor_t;

endpackage

`default_nettype wire

// File: rtl/frac_tick_divider.sv
// ============================================================================
// Module      : frac_tick_divider
// Description : Fractional clock divider. Counts act_int (+1 when stretched)
//               clocks per period and accumulates the fractional part; a carry
//               out of the accumulator stretches the following period by one.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frac_tick_divider #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_enable,
  input  logic              i_restart,
  input  logic              i_apply,
  input  logic [DIV_W-1:0]  i_div_int,
  input  logic [FRAC_W-1:0] i_div_frac,
  output logic              o_os_tick,
  output logic              o_term
);

  logic [DIV_W-1:0]  r_cnt;
  logic [FRAC_W-1:0] r_acc;
  logic              r_extra;
  logic              r_os_tick;
  logic [DIV_W-1:0]  w_last;
  logic [FRAC_W:0]   w_acc_sum;
  logic              w_term;

  // Terminal count of the current period, including the stretch bit.
  assign w_last    = i_div_int - DIV_W'(1) + DIV_W'(r_extra);
  assign w_acc_sum = {1'b0, r_acc} + {1'b0, i_div_frac};
  assign w_term    = i_enable && !i_restart && (r_cnt == w_last);

  // Period counter, fractional accumulator and registered os_tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_extra   <= 1'b0;
      r_os_tick <= 1'b0;
    end else if (i_restart) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_extra   <= 1'b0;
      r_os_tick <= 1'b0;
    end else if (w_term) begin
      r_cnt     <= '0;
      r_os_tick <= 1'b1;
      // A newly applied divisor starts from a clean fractional phase.
      if (i_apply) begin
        r_acc   <= '0;
        r_extra <= 1'b0;
      end else begin
        r_acc   <= w_acc_sum[FRAC_W-1:0];
        r_extra <= w_acc_sum[FRAC_W];
      end
    end else begin
      if (i_enable) begin
        r_cnt <= r_cnt + DIV_W'(1);
      end
      r_os_tick <= 1'b0;
    end
  end

  assign o_os_tick = r_os_tick;
  assign o_term    = w_term;

endmodule

`default_nettype wire

// File: rtl/baud_tick_gen.sv
// ============================================================================
// Module      : baud_tick_gen
// Description : Programmable UART baud tick generator. Produces oversample,
//               mid-bit and end-of-bit ticks; new divisors are staged in a
//               shadow register and applied at a period boundary or restart.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int DIV_W            = uart_pkg::DIV_W_DEF,
  parameter int FRAC_W           = uart_pkg::FRAC_W_DEF,
  parameter int OVERSAMPLE       = uart_pkg::OVERSAMPLE,
  parameter int DEFAULT_DIV_INT  = uart_pkg::DEFAULT_DIV_INT,
  parameter int DEFAULT_DIV_FRAC = uart_pkg::DEFAULT_DIV_FRAC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              restart,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  output logic              os_tick,
  output logic              mid_tick,
  output logic              bit_tick,
  output logic              load_pending,
  output logic              cfg_err
);

  localparam int                OSC_W   = $clog2(OVERSAMPLE);
  localparam logic [OSC_W-1:0]  c_MID   = OSC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OSC_W-1:0]  c_LAST  = OSC_W'(OVERSAMPLE - 1);
  localparam logic [DIV_W-1:0]  c_DEF_I = DIV_W'(DEFAULT_DIV_INT);
  localparam logic [FRAC_W-1:0] c_DEF_F = FRAC_W'(DEFAULT_DIV_FRAC);
  localparam logic [DIV_W-1:0]  c_MIN_I = DIV_W'(2);

  logic [DIV_W-1:0]  r_act_int;
  logic [FRAC_W-1:0] r_act_frac;
  logic [DIV_W-1:0]  r_shd_int;
  logic [FRAC_W-1:0] r_shd_frac;
  logic              r_pending;
  logic              r_cfg_err;
  logic [OSC_W-1:0]  r_os_cnt;
  logic              r_mid;
  logic              r_bit;

  logic w_term;
  logic w_os_tick;
  logic w_apply;
  logic w_load_ok;
  logic w_load_bad;

  assign w_load_ok  = div_load && (div_int >= c_MIN_I);
  assign w_load_bad = div_load && (div_int <  c_MIN_I);
  assign w_apply    = r_pending && (restart || w_term);

  frac_tick_divider #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) u_div (
    .clk        (clk),
    .reset      (reset),
    .i_enable   (enable),
    .i_restart  (restart),
    .i_apply    (w_apply),
    .i_div_int  (r_act_int),
    .i_div_frac (r_act_frac),
    .o_os_tick  (w_os_tick),
    .o_term     (w_term)
  );

  // Shadow capture, validation and glitch-free transfer to the active divisor.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_act_int  <= c_DEF_I;
      r_act_frac <= c_DEF_F;
      r_shd_int  <= c_DEF_I;
      r_shd_frac <= c_DEF_F;
      r_pending  <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_cfg_err <= w_load_bad;
      if (w_apply) begin
        r_act_int  <= r_shd_int;
        r_act_frac <= r_shd_frac;
      end
      // A load coinciding with an apply stages the newer value behind it.
      if (w_load_ok) begin
        r_shd_int  <= div_int;
        r_shd_frac <= div_frac;
        r_pending  <= 1'b1;
      end else if (w_apply) begin
        r_pending  <= 1'b0;
      end
    end
  end

  // Oversample position within the bit and mid/end-of-bit decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_os_cnt <= '0;
      r_mid    <= 1'b0;
      r_bit    <= 1'b0;
    end else if (restart) begin
      r_os_cnt <= '0;
      r_mid    <= 1'b0;
      r_bit    <= 1'b0;
    end else if (w_term) begin
      r_os_cnt <= (r_os_cnt == c_LAST) ? '0 : r_os_cnt + OSC_W'(1);
      r_mid    <= (r_os_cnt == c_MID);
      r_bit    <= (r_os_cnt == c_LAST);
    end else begin
      r_mid    <= 1'b0;
      r_bit    <= 1'b0;
    end
  end

  assign os_tick      = w_os_tick;
  assign mid_tick     = r_mid;
  assign bit_tick     = r_bit;
  assign load_pending = r_pending;
  assign cfg_err      = r_cfg_err;

endmodule

`default_nettype wire

// File: tb/tb_baud_tick_gen.sv
// ============================================================================
// Module      : tb_baud_tick_gen
// Description : Scoreboard bench for baud_tick_gen. Tick times come from a
//               closed-form model: the k-th tick after a phase start falls
//               k*int + floor((k-1)*frac/2^F) enabled clocks later.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_baud_tick_gen;
  import uart_pkg::*;

  localparam int DW       = 16;
  localparam int FW       = 4;
  localparam int OS       = 16;
  localparam int DEF_INT  = 10;
  localparam int DEF_FRAC = 0;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          restart = 1'b0;
  logic          div_load = 1'b0;
  logic [DW-1:0] div_int = '0;
  logic [FW-1:0] div_frac = '0;
  logic          os_tick, mid_tick, bit_tick, load_pending, cfg_err;

  always #5 clk = ~clk;

  baud_tick_gen dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .restart      (restart),
    .div_int      (div_int),
    .div_frac     (div_frac),
    .div_load     (div_load),
    .os_tick      (os_tick),
    .mid_tick     (mid_tick),
    .bit_tick     (bit_tick),
    .load_pending (load_pending),
    .cfg_err      (cfg_err)
  );

  int         n_vec = 0;
  int         n_bad = 0;
  longint     cyc = 0;
  logic [4:0] exp_q[$];
  longint     tick_t[$];

  // Reference model state
  divisor_t m_act, m_shd;
  logic     m_pend;
  longint   m_k, m_e, m_osn;

  function automatic longint tick_time(input longint k);
    return k * longint'(m_act.div_int) + ((k - 1) * longint'(m_act.div_frac)) / (longint'(1) << FW);
  endfunction

  task automatic model_reset();
    m_act.div_int  = DW'(DEF_INT);
    m_act.div_frac = FW'(DEF_FRAC);
    m_shd          = m_act;
    m_pend         = 1'b0;
    m_k = 0; m_e = 0; m_osn = 0;
  endtask

  task automatic model_step(input logic en, input logic rs, input logic ld,
                            input logic [DW-1:0] di, input logic [FW-1:0] df);
    logic os, md, bt, ce, ap;
    os = 1'b0; md = 1'b0; bt = 1'b0; ce = 1'b0; ap = 1'b0;
    if (rs) begin
      ap = m_pend; m_e = 0; m_k = 0; m_osn = 0;
    end else if (en) begin
      m_e++;
      if (m_e == tick_time(m_k + 1)) begin
        os = 1'b1;
        md = (m_osn == OS / 2 - 1);
        bt = (m_osn == OS - 1);
        m_osn = (m_osn + 1) % OS;
        m_k++;
        if (m_pend) begin
          ap = 1'b1; m_e = 0; m_k = 0;
        end
      end
    end
    if (ap) begin
      m_act  = m_shd;
      m_pend = 1'b0;
    end
    if (ld) begin
      if (di < 2) ce = 1'b1;
      else begin
        m_shd.div_int = di; m_shd.div_frac = df; m_pend = 1'b1;
      end
    end
    exp_q.push_back({os, md, bt, m_pend, ce});
  endtask

  task automatic drive(input logic en, input logic rs, input logic ld,
                       input logic [DW-1:0] di, input logic [FW-1:0] df);
    @(negedge clk);
    enable = en; restart = rs; div_load = ld; div_int = di; div_frac = df;
    if (reset) model_step(en, rs, ld, di, df);
    else exp_q.push_back(5'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic check(input string name, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic reset_assert();
    @(negedge clk);
    reset = 1'b0; enable = 1'b0; restart = 1'b0; div_load = 1'b0;
    #1;
    check("async_reset_outputs", longint'({os_tick, mid_tick, bit_tick, load_pending, cfg_err}), 0);
    model_reset();
    exp_q.push_back(5'b0);
  endtask

  task automatic reset_release();
    @(negedge clk);
    reset = 1'b1; enable = 1'b1; restart = 1'b0; div_load = 1'b0;
    model_step(1'b1, 1'b0, 1'b0, '0, '0);
  endtask

  // Monitor: compare every sampled output vector against the scoreboard.
  initial begin
    logic [4:0] e, a;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (os_tick) tick_t.push_back(cyc);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {os_tick, mid_tick, bit_tick, load_pending, cfg_err};
        n_vec++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL outputs cyc=%0d: os/mid/bit/pend/err got %b, required %b", cyc, a, e);
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) drive(1'b0, 1'b0, 1'b0, '0, '0);
    reset_release();
    idle(330);

    // Fractional divisor 10 + 8/16, phased by restart.
    drive(1'b1, 1'b0, 1'b1, DW'(10), FW'(8));
    drive(1'b1, 1'b1, 1'b0, '0, '0);
    tick_t.delete();
    idle(360);
    if (tick_t.size() >= 33) begin
      check("frac_period2", tick_t[1] - tick_t[0], 10);
      check("frac_period3", tick_t[2] - tick_t[1], 11);
      check("frac_period4", tick_t[3] - tick_t[2], 10);
      check("frac_sum_2_33", tick_t[32] - tick_t[0], 336);
    end else begin
      check("frac_tick_count", tick_t.size(), 33);
    end

    // Back to default, then a mid-period load of 20 at cnt=4.
    drive(1'b1, 1'b0, 1'b1, DW'(10), FW'(0));
    drive(1'b1, 1'b1, 1'b0, '0, '0);
    idle(4);
    drive(1'b1, 1'b0, 1'b1, DW'(20), FW'(0));
    tick_t.delete();
    idle(40);
    if (tick_t.size() >= 2) check("load20_period", tick_t[1] - tick_t[0], 20);
    else check("load20_tick_count", tick_t.size(), 2);

    // Restore default, then restart at os_cnt=5, cnt=3.
    drive(1'b1, 1'b0, 1'b1, DW'(10), FW'(0));
    drive(1'b1, 1'b1, 1'b0, '0, '0);
    idle(53);
    drive(1'b1, 1'b1, 1'b0, '0, '0);
    idle(170);

    // Rejected load.
    drive(1'b1, 1'b0, 1'b1, DW'(1), FW'(3));
    idle(30);
    drive(1'b1, 1'b0, 1'b1, DW'(0), FW'(0));
    idle(5);

    // Pending 20, enable low for 5 cycles, then async reset mid-bit.
    drive(1'b1, 1'b0, 1'b1, DW'(20), FW'(0));
    repeat (5) drive(1'b0, 1'b0, 1'b0, '0, '0);
    reset_assert();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    reset_release();
    idle(60);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        reset_assert();
        reset_release();
      end else begin
        drive($urandom_range(0, 9) != 0,
              $urandom_range(0, 99) == 0,
              $urandom_range(0, 29) == 0,
              DW'($urandom_range(0, 25)),
              FW'($urandom));
      end
    end

    idle(2);
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
